// File: rtl/irq_pkg.sv
// Shared types and defaults for the multi-source interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam int unsigned NSRC_DEFAULT = 4;

endpackage

// File: rtl/irq_controller_if.sv
// Device/processor-side signal bundle of irq_controller.
// The controller takes the slave view; the driving environment takes the master view.
interface irq_controller_if
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = NSRC_DEFAULT
);
  localparam int unsigned IDW = $clog2(NSRC);

  logic [NSRC-1:0] irq_in;
  logic [NSRC-1:0] irq_mask;
  logic            ExtIAck;
  logic            eoi;
  logic            clr_overrun;
  logic            ExtIRQ;
  logic [IDW-1:0]  irq_id;
  logic [NSRC-1:0] irq_pending;
  logic [NSRC-1:0] irq_overrun;
  logic            irq_busy;

  modport master (
    output irq_in, irq_mask, ExtIAck, eoi, clr_overrun,
    input  ExtIRQ, irq_id, irq_pending, irq_overrun, irq_busy
  );

  modport slave (
    input  irq_in, irq_mask, ExtIAck, eoi, clr_overrun,
    output ExtIRQ, irq_id, irq_pending, irq_overrun, irq_busy
  );
endinterface

// File: rtl/irq_controller_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after last_grant+1,
// wrapping modulo NSRC.
module irq_controller_rr_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = NSRC_DEFAULT,
  parameter int unsigned IDW  = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] elig,
  input  logic [IDW-1:0]  last_grant,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  int unsigned     off;
  logic [NSRC-1:0] rot;

  always_comb begin
    off = (32'(last_grant) + 32'd1) % NSRC;
    rot = '0;
    for (int unsigned j = 0; j < NSRC; j++) begin
      rot[j] = elig[(j + off) % NSRC];
    end
  end

  // Scan downward so the lowest rotated index is the last, and winning, assignment.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int unsigned j = NSRC; j > 0; j--) begin
      if (rot[j-1]) begin
        any    = 1'b1;
        winner = IDW'((j - 1 + off) % NSRC);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-latching, maskable, round-robin interrupt controller driving a single
// ExtIRQ line with an ack / end-of-interrupt handshake.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = NSRC_DEFAULT
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  irq_controller_if.slave    bus
);

  localparam int unsigned IDW = $clog2(NSRC);

  irq_state_t      state_q, state_d;
  logic [NSRC-1:0] prev_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] ovr_q, ovr_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            irq_q, irq_d;

  logic [NSRC-1:0] edge_det;
  logic [NSRC-1:0] ack_clr;
  logic [NSRC-1:0] elig;
  logic [IDW-1:0]  winner;
  logic            any;

  assign edge_det = bus.irq_in & ~prev_q;
  assign elig     = pend_q & ~bus.irq_mask;

  irq_controller_rr_arbiter #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_arb (
    .elig       (elig),
    .last_grant (last_q),
    .winner     (winner),
    .any        (any)
  );

  // A new edge outranks the ack clear, and only counts as overrun if the bit survives.
  always_comb begin
    ack_clr = '0;
    if (state_q == REQ && bus.ExtIAck) ack_clr[id_q] = 1'b1;
    pend_d = (pend_q & ~ack_clr) | edge_det;
    ovr_d  = (bus.clr_overrun ? '0 : ovr_q) | (edge_det & pend_q & ~ack_clr);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    irq_d   = irq_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          id_d    = winner;
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.ExtIAck) begin
          irq_d   = 1'b0;
          last_d  = id_q;
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.eoi) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      last_q  <= IDW'(NSRC - 1);
      id_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= bus.irq_in;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      last_q  <= last_d;
      id_q    <= id_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.ExtIRQ      = irq_q;
  assign bus.irq_id      = id_q;
  assign bus.irq_pending = pend_q;
  assign bus.irq_overrun = ovr_q;
  assign bus.irq_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed-vector bench for irq_controller with NSRC=4.
module tb_irq_controller;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b0;
  int   nvec     = 0;
  int   nerr     = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  irq_controller_if #(.NSRC(4)) bus ();

  irq_controller #(.NSRC(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Waits (bounded) for ExtIRQ, checks the granted id, then acks and ends the interrupt.
  task automatic serve(input string tag, input int exp_id);
    int n = 0;
    while (bus.ExtIRQ !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(bus.ExtIRQ), 32'd1);
    check({tag, "_id"}, 32'(bus.irq_id), 32'(exp_id));
    bus.ExtIAck = 1'b1;
    tick();
    bus.ExtIAck = 1'b0;
    check({tag, "_drop"}, 32'(bus.ExtIRQ), 32'd0);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    check({tag, "_idle"}, 32'(bus.irq_busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50);
    #3 reset = 1'b0;
    #4 reset = 1'b1;
    tick();
  endtask

  initial begin
    bus.irq_in      = '0;
    bus.irq_mask    = '0;
    bus.ExtIAck     = 1'b0;
    bus.eoi         = 1'b0;
    bus.clr_overrun = 1'b0;

    // 1. reset values, then a single edge on source 2
    #20;
    check("rst_irq",  32'(bus.ExtIRQ),      32'd0);
    check("rst_pend", 32'(bus.irq_pending), 32'h0);
    check("rst_busy", 32'(bus.irq_busy),    32'd0);
    check("rst_id",   32'(bus.irq_id),      32'd0);
    #2 reset = 1'b1;
    tick();
    bus.irq_in = 4'b0100;
    tick();
    bus.irq_in = 4'b0000;
    check("t1_pend", 32'(bus.irq_pending), 32'h4);
    check("t1_irq0", 32'(bus.ExtIRQ),      32'd0);
    tick();
    check("t1_irq", 32'(bus.ExtIRQ),   32'd1);
    check("t1_id",  32'(bus.irq_id),   32'd2);
    check("t1_bsy", 32'(bus.irq_busy), 32'd1);

    // 2. ack / eoi, then a stray ack while idle
    bus.ExtIAck = 1'b1;
    tick();
    bus.ExtIAck = 1'b0;
    check("t2_irq",  32'(bus.ExtIRQ),      32'd0);
    check("t2_pend", 32'(bus.irq_pending), 32'h0);
    check("t2_bsy",  32'(bus.irq_busy),    32'd1);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    check("t2_idle", 32'(bus.irq_busy), 32'd0);
    bus.ExtIAck = 1'b1;
    tick();
    bus.ExtIAck = 1'b0;
    tick();
    check("t2_stray_bsy", 32'(bus.irq_busy), 32'd0);
    check("t2_stray_irq", 32'(bus.ExtIRQ),   32'd0);

    // 3. round-robin order from a fresh last_grant of 3
    do_reset();
    bus.irq_in = 4'b1011;
    tick();
    bus.irq_in = 4'b0000;
    check("t3_pend", 32'(bus.irq_pending), 32'hB);
    serve("t3_a", 0);
    serve("t3_b", 1);
    serve("t3_c", 3);
    bus.irq_in = 4'b0011;
    tick();
    bus.irq_in = 4'b0000;
    serve("t3_d", 0);
    serve("t3_e", 1);

    // 4. masking holds off a pending source; masking during REQ does not retract
    bus.irq_mask = 4'b0001;
    bus.irq_in   = 4'b0001;
    tick();
    bus.irq_in = 4'b0000;
    tick();
    tick();
    check("t4_mask_irq",  32'(bus.ExtIRQ),      32'd0);
    check("t4_mask_pend", 32'(bus.irq_pending), 32'h1);
    check("t4_mask_bsy",  32'(bus.irq_busy),    32'd0);
    bus.irq_mask = 4'b0000;
    tick();
    check("t4_irq", 32'(bus.ExtIRQ), 32'd1);
    check("t4_id",  32'(bus.irq_id), 32'd0);
    bus.irq_mask = 4'b0001;
    tick();
    tick();
    check("t4_hold", 32'(bus.ExtIRQ), 32'd1);
    bus.ExtIAck = 1'b1;
    tick();
    bus.ExtIAck = 1'b0;
    check("t4_ack", 32'(bus.ExtIRQ), 32'd0);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    bus.irq_mask = 4'b0000;

    // 5. overrun while servicing source 1, clear, then edge coincident with ack
    bus.irq_in = 4'b0010;
    tick();
    bus.irq_in = 4'b0000;
    tick();
    check("t5_id", 32'(bus.irq_id), 32'd1);
    bus.ExtIAck = 1'b1;
    tick();
    bus.ExtIAck = 1'b0;
    bus.irq_in = 4'b0010;
    tick();
    bus.irq_in = 4'b0000;
    tick();
    bus.irq_in = 4'b0010;
    tick();
    bus.irq_in = 4'b0000;
    check("t5_pend", 32'(bus.irq_pending), 32'h2);
    check("t5_ovr",  32'(bus.irq_overrun), 32'h2);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    check("t5_ovr_clr", 32'(bus.irq_overrun), 32'h0);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    tick();
    check("t5_regrant", 32'(bus.ExtIRQ), 32'd1);
    check("t5_reid",    32'(bus.irq_id), 32'd1);
    bus.ExtIAck = 1'b1;
    bus.irq_in  = 4'b0010;
    tick();
    bus.ExtIAck = 1'b0;
    bus.irq_in  = 4'b0000;
    check("t5_coinc_pend", 32'(bus.irq_pending), 32'h2);
    check("t5_coinc_ovr",  32'(bus.irq_overrun), 32'h0);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    serve("t5_again", 1);

    // 6. asynchronous reset in REQ, no re-issue without a new edge
    bus.irq_in = 4'b0100;
    tick();
    bus.irq_in = 4'b0000;
    tick();
    check("t6_req", 32'(bus.ExtIRQ), 32'd1);
    check("t6_id",  32'(bus.irq_id), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("t6_async_irq",  32'(bus.ExtIRQ),      32'd0);
    check("t6_async_bsy",  32'(bus.irq_busy),    32'd0);
    check("t6_async_pend", 32'(bus.irq_pending), 32'h0);
    check("t6_async_id",   32'(bus.irq_id),      32'd0);
    #3 reset = 1'b1;
    tick();
    tick();
    tick();
    check("t6_noreissue", 32'(bus.ExtIRQ), 32'd0);
    bus.irq_in = 4'b1000;
    tick();
    bus.irq_in = 4'b0000;
    tick();
    check("t6_new_irq", 32'(bus.ExtIRQ), 32'd1);
    check("t6_new_id",  32'(bus.irq_id), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
